ethernet_tx_streamer: RTL and testbench

Multi-slot Ethernet transmit buffer and AXI-Stream sender, generalised from the two-slot 32/64-bit sender.
- Host writes whole frames into a ring of slots through a word/byte-mask write port, then commits each slot.
- The block streams committed frames out on tx_axis in commit order.
- A slot is released only after the last beat is accepted.
- Supports any power-of-two data width and a host-side abort of a partially written frame.

---
 rtl/ethernet_tx_streamer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ethernet_tx_streamer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_tx_streamer.sv
// ethernet_tx_streamer: multi-slot Ethernet transmit buffer feeding an
// AXI-Stream master. The host fills a ring of frame slots through a
// word/byte-mask write port and commits them; committed frames are streamed
// out in commit order, and a slot is recycled once its last beat is taken.
//
// Build option: define ETHERNET_TX_PAD_EN to pad short frames to 60 bytes
// (bytes past the written size are forced to zero on tdata).

module ethernet_tx_streamer #(
  parameter int data_width_p = 64,
  parameter int eth_mtu_p    = 2048,
  parameter int slots_p      = 4,
  parameter int send_count_p = 65535
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  output logic                               packet_req_o,
  input  logic                               packet_wsize_valid_i,
  input  logic [$clog2(eth_mtu_p+1)-1:0]     packet_wsize_i,
  input  logic                               packet_wvalid_i,
  input  logic [$clog2(eth_mtu_p)-1:0]       packet_waddr_i,
  input  logic [data_width_p-1:0]            packet_wdata_i,
  input  logic [data_width_p/8-1:0]          packet_wmask_i,
  input  logic                               packet_send_i,
  input  logic                               packet_abort_i,
  output logic [data_width_p-1:0]            tx_axis_tdata_o,
  output logic [data_width_p/8-1:0]          tx_axis_tkeep_o,
  output logic                               tx_axis_tvalid_o,
  output logic                               tx_axis_tlast_o,
  input  logic                               tx_axis_tready_i,
  output logic                               tx_axis_tuser_o,
  output logic [$clog2(slots_p+1)-1:0]       slots_free_o,
  output logic [$clog2(send_count_p+1)-1:0]  send_count_o
);

  localparam int num_bytes  = data_width_p / 8;
  localparam int lane_bits  = $clog2(num_bytes);
  localparam int size_bits  = $clog2(eth_mtu_p + 1);
  localparam int addr_bits  = $clog2(eth_mtu_p);
  localparam int beat_bits  = addr_bits - lane_bits;
  localparam int slot_bits  = $clog2(slots_p);
  localparam int fill_bits  = $clog2(slots_p + 1);
  localparam int count_bits = $clog2(send_count_p + 1);
  localparam int mem_depth  = slots_p << beat_bits;
  localparam int min_frame  = 60;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state_reg, state_next;
  logic [slot_bits-1:0]    wr_slot_reg, rd_slot_reg;
  logic [fill_bits-1:0]    filled_reg;
  logic [size_bits-1:0]    size_reg [slots_p];
  logic [beat_bits-1:0]    rd_beat_reg;
  logic                    issued_all_reg;
  logic [count_bits-1:0]   send_count_reg;
  logic                    tvalid_reg, tlast_reg;
  logic [num_bytes-1:0]    tkeep_reg;
`ifdef ETHERNET_TX_PAD_EN
  logic [num_bytes-1:0]    byte_live_reg;
  logic [num_bytes-1:0]    sel_live;
`endif

  logic                    wr_open, commit, release_frame, issue;
  logic [size_bits-1:0]    commit_size;
  logic [slot_bits+beat_bits-1:0] wr_addr, rd_addr;

  logic [slot_bits-1:0]    sel_slot;
  logic [beat_bits-1:0]    sel_beat, end_beat;
  logic                    sel_pending, sel_avail, sel_last;
  logic [size_bits-1:0]    sel_size, eff_size, eff_minus1;
  logic [lane_bits-1:0]    rem;
  logic [num_bytes-1:0]    last_keep, sel_keep;

  // Sub-word address bits carry no information: writes are word aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^packet_waddr_i[lane_bits-1:0];

  // Host side: a slot is open for writing while not every slot is committed.
  assign wr_open       = (filled_reg != fill_bits'(slots_p));
  assign commit_size   = packet_wsize_valid_i ? packet_wsize_i : size_reg[wr_slot_reg];
  assign commit        = wr_open & packet_send_i & ~packet_abort_i & (commit_size != '0);
  assign release_frame = tvalid_reg & tx_axis_tready_i & tlast_reg;
  assign wr_addr       = {wr_slot_reg, packet_waddr_i[lane_bits +: beat_bits]};
  assign rd_addr       = {sel_slot, sel_beat};

  assign packet_req_o     = wr_open;
  assign slots_free_o     = fill_bits'(slots_p) - filled_reg;
  assign send_count_o     = send_count_reg;
  assign tx_axis_tvalid_o = tvalid_reg;
  assign tx_axis_tlast_o  = tlast_reg;
  assign tx_axis_tkeep_o  = tkeep_reg;
  assign tx_axis_tuser_o  = 1'b0;

  // One RAM per byte lane so byte enables map onto plain write enables;
  // the lane read register doubles as the stream output data register.
  for (genvar gi = 0; gi < num_bytes; gi++) begin : g_lane
    logic [7:0] lane_mem [mem_depth];
    logic [7:0] lane_q;

    // Masked write from the host, registered read on beat issue.
    always_ff @(posedge clk_i) begin
      if (wr_open && packet_wvalid_i && packet_wmask_i[gi]) begin
        lane_mem[wr_addr] <= packet_wdata_i[gi*8 +: 8];
      end
      if (issue) begin
        lane_q <= lane_mem[rd_addr];
      end
    end

`ifdef ETHERNET_TX_PAD_EN
    assign tx_axis_tdata_o[gi*8 +: 8] = lane_q & {8{byte_live_reg[gi]}};
`else
    assign tx_axis_tdata_o[gi*8 +: 8] = lane_q;
`endif
  end

  // Per-slot frame size: abort clears it, a size strobe loads it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < slots_p; i++) begin
        size_reg[i] <= '0;
      end
    end else if (wr_open) begin
      if (packet_abort_i) begin
        size_reg[wr_slot_reg] <= '0;
      end else if (packet_wsize_valid_i) begin
        size_reg[wr_slot_reg] <= packet_wsize_i;
      end
    end
  end

  // Ring pointers, occupancy and the completed-frame counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_slot_reg    <= '0;
      rd_slot_reg    <= '0;
      filled_reg     <= '0;
      send_count_reg <= '0;
    end else begin
      if (commit) begin
        wr_slot_reg <= wr_slot_reg + slot_bits'(1);
      end
      if (release_frame) begin
        rd_slot_reg <= rd_slot_reg + slot_bits'(1);
        if (send_count_reg != count_bits'(send_count_p)) begin
          send_count_reg <= send_count_reg + count_bits'(1);
        end
      end
      case ({commit, release_frame})
        2'b10:   filled_reg <= filled_reg + fill_bits'(1);
        2'b01:   filled_reg <= filled_reg - fill_bits'(1);
        default: filled_reg <= filled_reg;
      endcase
    end
  end

  // Pick the beat to read next; on a release this already points at the
  // following frame so its first beat goes out without a bubble.
  always_comb begin
    sel_slot    = rd_slot_reg;
    sel_beat    = rd_beat_reg;
    sel_pending = ~issued_all_reg;
    sel_avail   = 1'b1;
    if (release_frame) begin
      sel_slot    = rd_slot_reg + slot_bits'(1);
      sel_beat    = '0;
      sel_pending = 1'b1;
      sel_avail   = (filled_reg > fill_bits'(1));
    end
    sel_size = size_reg[sel_slot];
`ifdef ETHERNET_TX_PAD_EN
    eff_size = (sel_size < size_bits'(min_frame)) ? size_bits'(min_frame) : sel_size;
`else
    eff_size = sel_size;
`endif
    eff_minus1 = eff_size - size_bits'(1);
    end_beat   = eff_minus1[lane_bits +: beat_bits];
    sel_last   = (sel_beat == end_beat);
    rem        = eff_size[lane_bits-1:0];
    for (int i = 0; i < num_bytes; i++) begin
      last_keep[i] = (rem == '0) || (lane_bits'(i) < rem);
    end
    sel_keep = sel_last ? last_keep : '1;
`ifdef ETHERNET_TX_PAD_EN
    for (int i = 0; i < num_bytes; i++) begin
      sel_live[i] = (size_bits'({sel_beat, lane_bits'(i)}) < sel_size);
    end
`endif
  end

  // Read FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Read FSM next state and read issue; a read goes out whenever the output
  // register will be free on the following cycle.
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (filled_reg != '0) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        issue = sel_avail & sel_pending & (~tvalid_reg | tx_axis_tready_i);
        if (release_frame) begin
          state_next = (filled_reg > fill_bits'(1)) ? STREAM : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Beat index within the current frame; frozen while the sink stalls.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_beat_reg    <= '0;
      issued_all_reg <= 1'b0;
    end else if (issue) begin
      issued_all_reg <= sel_last;
      rd_beat_reg    <= sel_last ? '0 : sel_beat + beat_bits'(1);
    end else if (release_frame) begin
      issued_all_reg <= 1'b0;
      rd_beat_reg    <= '0;
    end
  end

  // Output sideband register, loaded alongside the lane read data.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      tkeep_reg  <= '0;
`ifdef ETHERNET_TX_PAD_EN
      byte_live_reg <= '0;
`endif
    end else if (issue) begin
      tvalid_reg <= 1'b1;
      tlast_reg  <= sel_last;
      tkeep_reg  <= sel_keep;
`ifdef ETHERNET_TX_PAD_EN
      byte_live_reg <= sel_live;
`endif
    end else if (tx_axis_tready_i) begin
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      tkeep_reg  <= '0;
    end
  end

`ifndef SYNTHESIS
  // Flag host misuse: strobes with no open slot, or zero-length commits.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (wr_open || !(packet_wvalid_i || packet_wsize_valid_i ||
                           packet_send_i || packet_abort_i))
        else $warning("host write strobe ignored: no open slot");
      assert (!(wr_open && packet_send_i && !packet_abort_i && commit_size == '0))
        else $warning("zero-length frame commit ignored");
    end
  end
`endif

endmodule

// File: tb/tb_ethernet_tx_streamer.sv
// Bench for ethernet_tx_streamer: frames are written with random data/masks,
// the expected beat stream is derived from the byte image of each committed
// frame and checked every cycle the stream is valid.
module tb_ethernet_tx_streamer;
  localparam int NB  = 8;
  localparam int MTU = 2048;
`ifdef ETHERNET_TX_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        packet_req;
  logic        wsize_valid;
  logic [11:0] wsize;
  logic        wvalid;
  logic [10:0] waddr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        send, abort;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid, tlast, tready, tuser;
  logic [2:0]  slots_free;
  logic [15:0] send_count;

  ethernet_tx_streamer dut (
    .clk_i(clk), .reset_i(reset), .packet_req_o(packet_req),
    .packet_wsize_valid_i(wsize_valid), .packet_wsize_i(wsize),
    .packet_wvalid_i(wvalid), .packet_waddr_i(waddr), .packet_wdata_i(wdata),
    .packet_wmask_i(wmask), .packet_send_i(send), .packet_abort_i(abort),
    .tx_axis_tdata_o(tdata), .tx_axis_tkeep_o(tkeep), .tx_axis_tvalid_o(tvalid),
    .tx_axis_tlast_o(tlast), .tx_axis_tready_i(tready), .tx_axis_tuser_o(tuser),
    .slots_free_o(slots_free), .send_count_o(send_count)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [7:0]  cmp;
    logic        last;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] img [MTU];
  int checks = 0, errors = 0;
  int frames_model = 0, beats_seen = 0, bubbles = 0;
  bit count_bubbles = 0, rand_ready = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] bytemask(input logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < NB; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

  // Reference: cut the committed byte image into beats.
  task automatic queue_frame(input int size, output int nbeats, output logic [7:0] lastkeep);
    int eff;
    beat_t bt;
    eff = (PAD && size < 60) ? 60 : size;
    nbeats = (eff + NB - 1) / NB;
    lastkeep = 8'h00;
    for (int b = 0; b < nbeats; b++) begin
      bt.data = '0;
      bt.keep = '0;
      for (int i = 0; i < NB; i++) begin
        if (b*NB + i < size) bt.data[i*8 +: 8] = img[b*NB + i];
        if (b*NB + i < eff)  bt.keep[i] = 1'b1;
      end
      bt.cmp  = PAD ? 8'hFF : bt.keep;
      bt.last = (b == nbeats - 1);
      exp_q.push_back(bt);
      lastkeep = bt.keep;
    end
    frames_model++;
  endtask

  // Every valid cycle must show the head of the expected queue.
  always @(negedge clk) begin : compare_proc
    beat_t e;
    if (!reset) begin
      if (tvalid) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q[0];
          check("tdata", tdata & bytemask(e.cmp), e.data & bytemask(e.cmp));
          check("tkeep", tkeep, e.keep);
          check("tlast", tlast, e.last);
          if (tready) begin
            void'(exp_q.pop_front());
            beats_seen++;
          end
        end
      end else if (count_bubbles && exp_q.size() != 0) begin
        bubbles++;
      end
      check("tuser", tuser, 0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) tready = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_host();
    wsize_valid = 0; wvalid = 0; send = 0; abort = 0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (packet_req !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) check("req_timeout", packet_req, 1);
  endtask

  task automatic put_word(input int w, input logic [7:0] m, input bit with_send, input int size);
    logic [63:0] d;
    d = {$urandom, $urandom};
    wvalid = 1; waddr = 11'(w*NB + $urandom_range(0, NB-1)); wdata = d; wmask = m;
    if (with_send) begin
      send = 1; wsize_valid = 1; wsize = 12'(size);
    end
    for (int i = 0; i < NB; i++) if (m[i]) img[w*NB + i] = d[i*8 +: 8];
    step();
    clear_host();
  endtask

  task automatic load_frame(input int size, input bit combine, output int nbeats, output logic [7:0] lastkeep);
    int words;
    words = (size + NB - 1) / NB;
    wait_req();
    if (!combine) begin
      wsize_valid = 1; wsize = 12'(size);
      step();
      clear_host();
    end
    for (int w = 0; w < words; w++) put_word(w, 8'hFF, 1'b0, 0);
    for (int w = 0; w < words; w++) put_word(w, 8'($urandom), combine && (w == words-1), size);
    if (!combine) begin
      send = 1;
      step();
      clear_host();
    end
    queue_frame(size, nbeats, lastkeep);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tvalid) && n < 20000) begin
      step();
      n++;
    end
    check(name, 64'((exp_q.size() != 0) || tvalid), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int nb, b0, total;
    logic [7:0] lk;
    reset = 1; tready = 0; waddr = 0; wdata = 0; wmask = 0; wsize = 0;
    clear_host();
    repeat (3) step();
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tkeep", tkeep, 0);
    check("rst_tuser", tuser, 0);
    check("rst_slots_free", slots_free, 4);
    check("rst_send_count", send_count, 0);
    check("rst_req", packet_req, 1);
    reset = 0;
    step();

    // Single 64-byte frame.
    tready = 1;
    b0 = beats_seen;
    load_frame(64, 1'b0, nb, lk);
    check("t1_model_beats", nb, 8);
    check("t1_model_keep", lk, 8'hFF);
    check("t1_slots_busy", slots_free, 3);
    drain("t1_drain");
    check("t1_beats", beats_seen - b0, 8);
    check("t1_send_count", send_count, 1);
    check("t1_slots_free", slots_free, 4);

    // Partial last beat, then a single-word frame.
    b0 = beats_seen;
    load_frame(61, 1'b1, nb, lk);
    check("t2_model_beats", nb, 8);
    check("t2_model_keep", lk, 8'h1F);
    drain("t2a_drain");
    check("t2a_beats", beats_seen - b0, 8);
    b0 = beats_seen;
    load_frame(8, 1'b0, nb, lk);
    check("t2b_model_beats", nb, PAD ? 8 : 1);
    check("t2b_model_keep", lk, PAD ? 8'h0F : 8'hFF);
    drain("t2b_drain");
    check("t2b_beats", beats_seen - b0, PAD ? 8 : 1);
    check("t2_send_count", send_count, 3);

    // Fill every slot while the sink stalls.
    tready = 0;
    b0 = beats_seen;
    total = 0;
    load_frame(64, 1'b0, nb, lk);  total += nb;
    load_frame(130, 1'b1, nb, lk); total += nb;
    check("t3_model_keep", lk, 8'h03);
    load_frame(200, 1'b0, nb, lk); total += nb;
    load_frame(1, 1'b1, nb, lk);   total += nb;
    check("t3_model_keep1", lk, PAD ? 8'h0F : 8'h01);
    check("t3_req_full", packet_req, 0);
    check("t3_slots_full", slots_free, 0);
    wvalid = 1; waddr = 11'd8; wdata = {$urandom, $urandom}; wmask = 8'hFF;
    step();
    clear_host();
    repeat (3) step();
    check("t3_slots_still_full", slots_free, 0);
    bubbles = 0;
    count_bubbles = 1;
    tready = 1;
    drain("t3_drain");
    count_bubbles = 0;
    check("t3_bubbles", bubbles, 0);
    check("t3_beats", beats_seen - b0, total);
    check("t3_slots_free", slots_free, 4);
    check("t3_send_count", send_count, 7);

    // Long frame under random backpressure.
    b0 = beats_seen;
    rand_ready = 1;
    load_frame(1514, 1'b0, nb, lk);
    check("t4_model_beats", nb, 190);
    check("t4_model_keep", lk, 8'h03);
    drain("t4_drain");
    rand_ready = 0;
    step();
    tready = 1;
    check("t4_beats", beats_seen - b0, 190);

    // Abort a half-written frame; abort beats a simultaneous send.
    wsize_valid = 1; wsize = 12'd64;
    step();
    clear_host();
    for (int w = 0; w < 4; w++) put_word(w, 8'hFF, 1'b0, 0);
    abort = 1; send = 1;
    step();
    clear_host();
    repeat (5) step();
    check("t5_no_commit", slots_free, 4);
    check("t5_no_frame", send_count, 8);
    b0 = beats_seen;
    load_frame(16, 1'b1, nb, lk);
    check("t5_model_beats", nb, PAD ? 8 : 2);
    drain("t5_drain");
    check("t5_beats", beats_seen - b0, PAD ? 8 : 2);

    // Short frame: padded or not depending on the build.
    b0 = beats_seen;
    load_frame(20, 1'b0, nb, lk);
    check("t6_model_beats", nb, PAD ? 8 : 3);
    check("t6_model_keep", lk, 8'h0F);
    drain("t6_drain");
    check("t6_beats", beats_seen - b0, PAD ? 8 : 3);

    // Random frames streaming back to back through the ring.
    rand_ready = 1;
    for (int k = 0; k < 10; k++) begin
      load_frame($urandom_range(1, MTU), 1'($urandom_range(0, 1)), nb, lk);
    end
    drain("t7_drain");
    rand_ready = 0;
    step();
    tready = 1;
    check("t7_send_count", send_count, frames_model);
    check("t7_slots_free", slots_free, 4);

    // Reset in the middle of a frame.
    rand_ready = 1;
    load_frame(512, 1'b0, nb, lk);
    repeat (10) step();
    rand_ready = 0;
    reset = 1;
    exp_q.delete();
    step();
    check("t8_tvalid", tvalid, 0);
    check("t8_tkeep", tkeep, 0);
    check("t8_tlast", tlast, 0);
    check("t8_slots_free", slots_free, 4);
    check("t8_send_count", send_count, 0);
    check("t8_req", packet_req, 1);
    reset = 0;
    tready = 1;
    frames_model = 0;
    step();
    b0 = beats_seen;
    load_frame(64, 1'b0, nb, lk);
    drain("t8_drain");
    check("t8_beats", beats_seen - b0, 8);
    check("t8_send_count_after", send_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
